// File: rtl/byte_mem_ctrl.sv
// ---------------------------------------------------------------------------
// byte_mem_ctrl
//   Byte-addressed, little-endian data memory behind a valid/ready
//   request/response handshake. One access is in flight at a time:
//   IDLE accepts a request, WAIT burns WAIT_STATES cycles, RESP presents
//   the response until the consumer takes it. Multi-byte accesses wrap
//   modulo DEPTH_BYTES; addresses at or above DEPTH_BYTES answer with an
//   error and touch nothing.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (storage is not cleared)
//   req_valid  in   request present
//   req_ready  out  controller can accept a request (registered)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   byte address of the lowest byte
//   req_wdata  in   write data, byte k = req_wdata[8k+7:8k]
//   req_be     in   per-byte write enables (ignored on reads)
//   rsp_valid  out  response present (registered)
//   rsp_ready  in   consumer accepts the response
//   rsp_rdata  out  read data, 0 for writes and errors (registered)
//   rsp_err    out  latched address was out of range (registered)
// ---------------------------------------------------------------------------
module byte_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 16384,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int BA_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  // Last value of the wait counter before the FSM moves on to RESP.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  // Depth widened by one bit so the range compare also works when
  // DEPTH_BYTES == 2**ADDR_W (then nothing is ever out of range).
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // FSM and wait counter
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Latched request
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]      be_q, be_d;

  // Registered outputs
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  // Storage array; deliberately outside the reset domain.
  logic [7:0]         mem_array [DEPTH_BYTES];

  // Access view used on the commit edge
  logic               acc_write_s;
  logic [ADDR_W-1:0]  acc_addr_s;
  logic [DATA_W-1:0]  acc_wdata_s;
  logic [NB-1:0]      acc_be_s;
  logic [BA_W-1:0]    byte_addr_s [NB];
  logic [DATA_W-1:0]  rd_data_s;
  logic [DATA_W-1:0]  rsp_data_s;
  logic               oor_s;
  logic               commit_s;
  logic [NB-1:0]      mem_we_s;

  // Select the access operands: with zero wait states the commit happens on
  // the accept edge itself, so the live request must be used; otherwise the
  // latched copy is used.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write_s = req_write;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      acc_be_s    = req_be;
    end else begin
      acc_write_s = wr_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_be_s    = be_q;
    end
  end

  // Per-byte storage addresses (wrapping modulo the power-of-two depth) and
  // the little-endian read word assembled from them.
  always_comb begin
    rd_data_s = '0;
    for (int k = 0; k < NB; k++) begin
      byte_addr_s[k]      = acc_addr_s[BA_W-1:0] + BA_W'(k);
      rd_data_s[8*k +: 8] = mem_array[byte_addr_s[k]];
    end
  end

  assign oor_s      = ({1'b0, acc_addr_s} >= DEPTH_EXT);
  assign rsp_data_s = (acc_write_s || oor_s) ? {DATA_W{1'b0}} : rd_data_s;

  // Byte write strobes: only on the commit edge, only for in-range writes,
  // and never while reset is held so an abandoned access cannot land.
  always_comb begin
    mem_we_s = '0;
    if (commit_s && acc_write_s && !oor_s && reset_n) begin
      mem_we_s = acc_be_s;
    end else begin
      mem_we_s = '0;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (mem_we_s[k]) begin
        mem_array[byte_addr_s[k]] <= acc_wdata_s[8*k +: 8];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/WAIT/RESP handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d        = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          req_ready_d = 1'b0;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            // No wait states: commit and respond straight from the request.
            state_d     = ST_RESP;
            commit_s    = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rsp_data_s;
            rsp_err_d   = oor_s;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          cnt_d       = '0;
          commit_s    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rsp_data_s;
          rsp_err_d   = oor_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        // Response fields are frozen until the consumer takes them.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_byte_mem_ctrl
//   Directed bench for byte_mem_ctrl. The main instance (WAIT_STATES=1) is
//   checked every cycle against a transaction-level model (byte array plus
//   a "response due at cycle X" timeline); hand-computed literals pin the
//   model. A second instance (WAIT_STATES=3) covers reset during WAIT.
// ---------------------------------------------------------------------------
module tb_byte_mem_ctrl;

  localparam int WS    = 1;
  localparam int WS3   = 3;
  localparam int DEPTH = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic        reset_n = 1'b0;
  logic        req_valid, req_write, rsp_ready;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;

  // Second instance signals
  logic        d3_reset_n = 1'b0;
  logic        d3_req_valid, d3_req_write, d3_rsp_ready;
  logic [15:0] d3_req_addr, d3_req_wdata;
  logic [1:0]  d3_req_be;
  logic        d3_req_ready, d3_rsp_valid, d3_rsp_err;
  logic [15:0] d3_rsp_rdata;

  int checks = 0;
  int errors = 0;

  byte_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  byte_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(DEPTH), .WAIT_STATES(WS3)) u_dut3 (
    .clk(clk), .reset_n(d3_reset_n),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_write(d3_req_write),
    .req_addr(d3_req_addr), .req_wdata(d3_req_wdata), .req_be(d3_req_be),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model of the main instance ----------
  logic [7:0]  m_mem [DEPTH];
  logic        m_busy = 1'b0;   // a request has been accepted, not yet retired
  logic        m_rsp  = 1'b0;   // response is being presented
  logic [15:0] e_data = 16'h0000;
  logic        e_err  = 1'b0;
  int          m_cyc  = 0;
  int          m_due  = 0;
  logic        l_w;
  int          l_a;
  logic [15:0] l_d;
  logic [1:0]  l_be;

  task automatic model_commit();
    e_data = 16'h0000;
    e_err  = 1'b0;
    if (l_a >= DEPTH) begin
      e_err = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int b;
        b = (l_a + k) % DEPTH;
        if (l_w) begin
          if (l_be[k]) m_mem[b] = l_d[8*k +: 8];
        end else begin
          e_data[8*k +: 8] = m_mem[b];
        end
      end
    end
    m_rsp = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        // In-flight access is dropped; a write not yet due never lands.
        m_busy = 1'b0;
        m_rsp  = 1'b0;
        e_data = 16'h0000;
        e_err  = 1'b0;
      end else begin
        m_cyc++;
        if (m_rsp) begin
          if (rsp_ready) begin
            m_rsp  = 1'b0;
            m_busy = 1'b0;
          end
        end else if (!m_busy && req_valid) begin
          m_busy = 1'b1;
          m_due  = m_cyc + WS;
          l_w    = req_write;
          l_a    = int'(req_addr);
          l_d    = req_wdata;
          l_be   = req_be;
        end
        if (m_busy && !m_rsp && (m_cyc == m_due)) model_commit();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_req_ready", req_ready, !m_busy);
      chk("cyc_rsp_valid", rsp_valid, m_rsp);
      if (m_rsp) begin
        chk("cyc_rsp_rdata", rsp_rdata, e_data);
        chk("cyc_rsp_err", rsp_err, e_err);
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  // Present one request just after an edge; hold the response for 'hold'
  // cycles with rsp_ready low (while pushing an ignored request), then retire.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be, input int hold,
                        output logic [15:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_seen", rsp_valid, 1'b1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010;
      req_wdata = 16'hDEAD; req_be = 2'b11;
      @(posedge clk); #1;
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata, rd);
      chk("bp_rsp_err", rsp_err, er);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", rsp_valid, 1'b0);
    chk("post_hs_req_ready", req_ready, 1'b1);
  endtask

  task automatic d3_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be,
                        output logic [15:0] rd, output logic er, output int lat);
    d3_req_valid = 1'b1; d3_req_write = w; d3_req_addr = a; d3_req_wdata = d; d3_req_be = be;
    d3_rsp_ready = 1'b1;
    @(posedge clk); #1;
    d3_req_valid = 1'b0;
    lat = 1;
    while (!d3_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d3_rsp_seen", d3_rsp_valid, 1'b1);
    rd = d3_rsp_rdata;
    er = d3_rsp_err;
    @(posedge clk); #1;
    d3_rsp_ready = 1'b0;
  endtask

  // ---------------- directed sequence -------------------------------------
  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;

    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    req_be = 2'b00; rsp_ready = 1'b0;
    d3_req_valid = 1'b0; d3_req_write = 1'b0; d3_req_addr = 16'h0000;
    d3_req_wdata = 16'h0000; d3_req_be = 2'b00; d3_rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_rsp_err", rsp_err, 1'b0);
    reset_n = 1'b1;
    d3_reset_n = 1'b1;
    @(posedge clk); #1;

    // T1: full write then read back, response two cycles after presenting
    do_req(1'b1, 16'h0010, 16'hBEEF, 2'b11, 0, rd, er, lat);
    chk("t1_wr_err", er, 1'b0);
    chk("t1_wr_rdata", rd, 16'h0000);
    chk("t1_wr_lat", lat, 2);
    do_req(1'b0, 16'h0010, 16'h0000, 2'b00, 0, rd, er, lat);
    chk("t1_rd", rd, 16'hBEEF);
    chk("t1_rd_lat", lat, 2);

    // T2: upper-byte-only write
    do_req(1'b1, 16'h0010, 16'h1234, 2'b10, 0, rd, er, lat);
    do_req(1'b0, 16'h0010, 16'h0000, 2'b00, 0, rd, er, lat);
    chk("t2_rd", rd, 16'h12EF);
    chk("t2_err", er, 1'b0);

    // T3: wrap from the top byte to byte 0 (byte 1 preset so it is known)
    do_req(1'b1, 16'h0000, 16'hC3C3, 2'b11, 0, rd, er, lat);
    do_req(1'b1, 16'h3FFF, 16'hA55A, 2'b11, 0, rd, er, lat);
    do_req(1'b0, 16'h3FFF, 16'h0000, 2'b00, 0, rd, er, lat);
    chk("t3_rd_top", rd, 16'hA55A);
    do_req(1'b0, 16'h0000, 16'h0000, 2'b00, 0, rd, er, lat);
    chk("t3_rd_zero", rd, 16'hC3A5);

    // T4: out-of-range write and read
    do_req(1'b1, 16'h4000, 16'hFFFF, 2'b11, 0, rd, er, lat);
    chk("t4_wr_err", er, 1'b1);
    chk("t4_wr_rdata", rd, 16'h0000);
    chk("t4_wr_lat", lat, 2);
    do_req(1'b0, 16'hFFFF, 16'h0000, 2'b00, 0, rd, er, lat);
    chk("t4_rd_err", er, 1'b1);
    chk("t4_rd_rdata", rd, 16'h0000);
    do_req(1'b0, 16'h0000, 16'h0000, 2'b00, 0, rd, er, lat);
    chk("t4_rd_zero", rd, 16'hC3A5);
    chk("t4_rd_zero_err", er, 1'b0);

    // Write with no byte enables: acknowledged, storage unchanged
    do_req(1'b1, 16'h0000, 16'h1111, 2'b00, 0, rd, er, lat);
    chk("be0_err", er, 1'b0);
    do_req(1'b0, 16'h0000, 16'h0000, 2'b00, 0, rd, er, lat);
    chk("be0_rd", rd, 16'hC3A5);

    // T5: five cycles of back-pressure with a request pushed meanwhile
    do_req(1'b0, 16'h0010, 16'h0000, 2'b00, 5, rd, er, lat);
    chk("t5_rd", rd, 16'h12EF);
    do_req(1'b0, 16'h0010, 16'h0000, 2'b00, 0, rd, er, lat);
    chk("t5_ignored_wr", rd, 16'h12EF);

    // T6: WAIT_STATES=3, reset in the second WAIT cycle abandons the write
    d3_req(1'b1, 16'h0020, 16'h0102, 2'b11, rd, er, lat);
    chk("t6_pre_wr_lat", lat, 4);
    d3_req(1'b0, 16'h0020, 16'h0000, 2'b00, rd, er, lat);
    chk("t6_pre_rd", rd, 16'h0102);
    chk("t6_pre_rd_lat", lat, 4);
    d3_req_valid = 1'b1; d3_req_write = 1'b1; d3_req_addr = 16'h0020;
    d3_req_wdata = 16'h7777; d3_req_be = 2'b11; d3_rsp_ready = 1'b1;
    @(posedge clk); #1;           // accepted, first WAIT cycle
    d3_req_valid = 1'b0;
    chk("t6_busy", d3_req_ready, 1'b0);
    @(posedge clk); #1;           // second WAIT cycle
    d3_reset_n = 1'b0;
    #1;
    chk("t6_rst_req_ready", d3_req_ready, 1'b1);
    chk("t6_rst_rsp_valid", d3_rsp_valid, 1'b0);
    chk("t6_rst_rsp_rdata", d3_rsp_rdata, 16'h0000);
    chk("t6_rst_rsp_err", d3_rsp_err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_rst_held_valid", d3_rsp_valid, 1'b0);
    d3_reset_n = 1'b1;
    @(posedge clk); #1;
    d3_req(1'b0, 16'h0020, 16'h0000, 2'b00, rd, er, lat);
    chk("t6_after_rst_rd", rd, 16'h0102);
    chk("t6_after_rst_err", er, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
